// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: one outstanding fetch, fixed-latency response
// from a loadable word store, with stall back to the PC stage.
module instr_fetch_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2,
  parameter logic [31:0] NOP     = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [31:0]              req_addr_i,
  output logic                     req_ready_o,
  output logic                     stall_o,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_instr_o,
  output logic [31:0]              rsp_addr_o,
  output logic                     rsp_err_o,
  input  logic                     load_en_i,
  input  logic [$clog2(DEPTH)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic [31:0]   fill_addr;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic          fill_fault;

  assign req_ready_o = (state == IDLE) || ((state == RESP) && rsp_ready_i);
  assign stall_o     = req_valid_i && !req_ready_o;
  assign accept      = req_valid_i && req_ready_o;

  // Word fetched on the edge entering RESP; a same-edge load to that word is forwarded.
  always_comb begin
    fill_addr  = (state == BUSY) ? addr_q : req_addr_i;
    rd_idx     = fill_addr[AW+1:2];
    rd_word    = (load_en_i && (load_addr_i == rd_idx)) ? load_data_i : mem[rd_idx];
    fill_fault = (fill_addr[1:0] != 2'b00) || (fill_addr[31:AW+2] != '0);
  end

  // Instruction store write port, independent of the fetch FSM.
  always_ff @(posedge clk_i) begin
    if (load_en_i) begin
      mem[load_addr_i] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      addr_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_instr_o <= '0;
      rsp_addr_o  <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE, RESP: begin
          if (accept) begin
            addr_q <= req_addr_i;
            if (LATENCY > 1) begin
              state       <= BUSY;
              cnt         <= CW'(LATENCY - 1);
              rsp_valid_o <= 1'b0;
            end else begin
              // Single-cycle build completes on the accept edge itself.
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_instr_o <= fill_fault ? NOP : rd_word;
              rsp_err_o   <= fill_fault;
              rsp_addr_o  <= fill_addr;
            end
          end else if ((state == RESP) && rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == CW'(1)) begin
            state       <= RESP;
            cnt         <= '0;
            rsp_valid_o <= 1'b1;
            rsp_instr_o <= fill_fault ? NOP : rd_word;
            rsp_err_o   <= fill_fault;
            rsp_addr_o  <= fill_addr;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
